// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and serializer handshake constants for the UART scheduler
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int TX_START_CYCLES = 1;
  localparam int TX_BUSY_LAG = 1;
  typedef enum logic [2:0] {IDLE, SEND, LAUNCH, WAIT, GAP} state_t;
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: round-robin winner search starting just above ptr, with wrap
module uart_rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);
  always_comb begin
    winner = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) winner = W'((int'(ptr) + k) % N);
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART byte serializer among N_REQ message sources
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_busy,
  output logic                       grant_active,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       abort_pulse
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  state_t state, state_n;
  logic [IW-1:0] ptr, winner;
  logic any_req, last_r, sel_valid, sel_last, timeout, gap_done;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [UART_BYTE_W-1:0] sel_data;
  uart_rr_picker #(.N(N_REQ)) picker (
    .req(req_valid),
    .ptr(ptr),
    .winner(winner),
    .any_req(any_req)
  );
  assign sel_valid = req_valid[grant_id];
  assign sel_last = req_last[grant_id];
  assign sel_data = req_data[grant_id*UART_BYTE_W +: UART_BYTE_W];
  assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign gap_done = gcnt == GW'(GAP_CYCLES);
  assign tx_start = state == LAUNCH;
  assign req_ready = state == SEND ? N_REQ'(1) << grant_id : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? SEND : IDLE;
      SEND:    state_n = sel_valid ? LAUNCH : timeout ? GAP : SEND;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = tx_busy ? WAIT : last_r ? GAP : SEND;
      GAP:     state_n = gap_done ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(N_REQ - 1);
      grant_id <= '0;
      grant_active <= 1'b0;
      tx_byte <= '0;
      last_r <= 1'b0;
      tcnt <= '0;
      gcnt <= '0;
      abort_pulse <= 1'b0;
    end else begin
      state <= state_n;
      abort_pulse <= state == SEND && !sel_valid && timeout;
      tcnt <= (state == SEND && !sel_valid && !timeout) ? tcnt + 1'b1 : '0;
      gcnt <= (state == GAP && !gap_done) ? gcnt + 1'b1 : '0;
      if (state == IDLE && any_req) begin
        grant_id <= winner;
        ptr <= winner;
        grant_active <= 1'b1;
      end
      if (state == SEND && sel_valid) begin
        tx_byte <= sel_data;
        last_r <= sel_last;
      end
      if ((state == SEND && !sel_valid && timeout) || (state == WAIT && !tx_busy && last_r))
        grant_active <= 1'b0;
    end
  end
endmodule
